// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole board blocks.
//   N_HOLES    : number of holes on the 3x3 board
//   NO_HIT     : hit_pos value meaning "no whack this cycle"
//   state_t    : mole scheduler FSM encoding
//   hole_idx_t : hole index type (0..8 valid)
//   wrap_idx   : folds a raw 4-bit random value into 0..8
//   popcount9  : number of set bits in a 9-bit hole map
package whack_pkg;

  localparam int unsigned N_HOLES = 9;
  localparam logic [3:0]  NO_HIT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PICK = 2'd2
  } state_t;

  typedef logic [3:0] hole_idx_t;

  // Values 9..15 fold to 0..6, so every hole can be a starting point.
  function automatic hole_idx_t wrap_idx(input logic [3:0] raw);
    return (raw >= 4'd9) ? raw - 4'd9 : raw;
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

endpackage

// File: rtl/mole_life_timer.sv
// Lifetime counter for a single hole.
//   clk, rst : clock, synchronous active-high clear
//   load     : start a new mole with lifetime life (wins over kill)
//   life     : lifetime in cycles for a newly loaded mole
//   kill     : mole whacked, drop it without expiring
//   up       : registered, mole currently in this hole
//   expire   : high during the last cycle of the lifetime (count == 1);
//              the mole is gone after the following edge
module mole_life_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] life,
  input  logic        kill,
  output logic        up,
  output logic        expire
);

  logic [31:0] count;

  assign expire = up && (count == 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      up    <= 1'b0;
    end else if (load) begin
      count <= life;
      up    <= (life != 32'd0);
    end else if (kill) begin
      count <= '0;
      up    <= 1'b0;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
      up    <= (count != 32'd1);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Per-hole mole scheduler for the 3x3 board: spawns moles into random free
// holes at a level-dependent interval, limits concurrent moles, expires each
// mole after its own lifetime, scores hits, and raises the level.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 1 = game running, 0 = synchronous clear (same as rst)
//   hit_pos    : one-cycle whack position 0..8, 15 = none, 9..14 ignored
//   rnd        : free-running LFSR value, rnd[3:0] seeds the probe start
//   map        : bit i = mole up in hole i
//   active_cnt : popcount(map)
//   level      : difficulty level 0..MAX_LEVEL
//   hit_pulse  : one cycle, a mole was whacked
//   miss_pulse : one cycle, at least one mole expired
//   bad_pulse  : one cycle, whack on an empty hole
//   fsm_state  : current scheduler state (debug observation)
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int unsigned SPAWN_BASE     = 50_000_000,
  parameter int unsigned SPAWN_STEP     = 5_000_000,
  parameter int unsigned LIFE_BASE      = 100_000_000,
  parameter int unsigned LIFE_STEP      = 10_000_000,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned MAX_ACTIVE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] hit_pos,
  input  logic [8:0] rnd,
  output logic [8:0] map,
  output logic [3:0] active_cnt,
  output logic [2:0] level,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       bad_pulse,
  output state_t     fsm_state
);

  state_t      state, state_nxt;
  logic        clr;
  logic [31:0] spawn_cnt, spawn_int, life_val;
  logic [31:0] hit_cnt;
  hole_idx_t   probe_idx;
  logic [3:0]  probe_num;
  logic [8:0]  dec, sel, kill, load, expire, live_after;
  logic        spawn_due, probe_free, bad;
  logic        rnd_unused;

  assign clr        = rst | ~en;
  assign rnd_unused = ^rnd[8:4];
  assign fsm_state  = state;
  // map is the timers' registered up bits, so this is a function of state only.
  assign active_cnt = popcount9(map);

  assign spawn_int = SPAWN_BASE - 32'(level) * SPAWN_STEP;
  assign life_val  = LIFE_BASE - 32'(level) * LIFE_STEP;
  // >= rather than ==: a level-up can shrink the interval below a count
  // already reached, which must not lose the attempt.
  assign spawn_due = (spawn_cnt >= spawn_int - 32'd1);

  always_comb begin
    dec = '0;
    sel = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      dec[i] = (hit_pos == 4'(i));
      sel[i] = (probe_idx == 4'(i));
    end
  end

  assign kill       = dec & map;
  assign bad        = (|dec) && !(|kill);
  // A hole being whacked or expiring this cycle is free for the probe.
  assign live_after = map & ~kill & ~expire;
  assign probe_free = |(sel & ~live_after);

  always_comb begin
    state_nxt = state;
    load      = '0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (spawn_due && (active_cnt < 4'(MAX_ACTIVE)) && (map != 9'h1FF))
          state_nxt = PICK;
      end
      PICK: begin
        if (probe_free) begin
          load      = sel;
          state_nxt = RUN;
        end else if (probe_num == 4'd8) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      spawn_cnt  <= '0;
      probe_idx  <= '0;
      probe_num  <= '0;
      hit_cnt    <= '0;
      level      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      bad_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hit_pulse  <= |kill;
      miss_pulse <= |(expire & ~kill);
      bad_pulse  <= bad;

      case (state)
        IDLE: spawn_cnt <= '0;
        RUN: begin
          // A skipped attempt restarts the interval just like a taken one.
          spawn_cnt <= spawn_due ? '0 : spawn_cnt + 32'd1;
          if (state_nxt == PICK) begin
            probe_idx <= wrap_idx(rnd[3:0]);
            probe_num <= '0;
          end
        end
        PICK: begin
          spawn_cnt <= spawn_cnt + 32'd1;
          probe_idx <= (probe_idx == 4'd8) ? 4'd0 : probe_idx + 4'd1;
          probe_num <= probe_num + 4'd1;
        end
        default: spawn_cnt <= '0;
      endcase

      if (|kill) begin
        if (hit_cnt == 32'(HITS_PER_LEVEL - 1)) begin
          hit_cnt <= '0;
          if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
        end else begin
          hit_cnt <= hit_cnt + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    mole_life_timer u_timer (
      .clk    (clk),
      .rst    (clr),
      .load   (load[g]),
      .life   (life_val),
      .kill   (kill[g]),
      .up     (map[g]),
      .expire (expire[g])
    );
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler. Instance a uses the reduced timing set
// (SPAWN 20/2, LIFE 50/5, 2 hits per level, 2 moles max); instance b uses
// 4 moles max and a long lifetime so that several holes can be held busy
// while the wrap-around probe is exercised.
module tb_mole_scheduler;
  import whack_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, en_b;
  logic [3:0] hit_pos;
  logic [8:0] rnd;

  logic [8:0] map_a, map_b;
  logic [3:0] act_a, act_b;
  logic [2:0] lvl_a, lvl_b;
  logic       hit_a, hit_b, miss_a, miss_b, bad_a, bad_b;
  state_t     st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int w;

  typedef struct {
    logic [3:0] hit;
    logic [8:0] map;
    logic       hit_p;
    logic       miss_p;
    logic       bad_p;
    logic [2:0] lvl;
    logic [3:0] act;
  } vec_t;

  vec_t tbl[10];

  mole_scheduler #(
    .SPAWN_BASE(20), .SPAWN_STEP(2), .LIFE_BASE(50), .LIFE_STEP(5),
    .MAX_LEVEL(7), .HITS_PER_LEVEL(2), .MAX_ACTIVE(2)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .hit_pos(hit_pos), .rnd(rnd),
    .map(map_a), .active_cnt(act_a), .level(lvl_a), .hit_pulse(hit_a),
    .miss_pulse(miss_a), .bad_pulse(bad_a), .fsm_state(st_a)
  );

  mole_scheduler #(
    .SPAWN_BASE(20), .SPAWN_STEP(2), .LIFE_BASE(200), .LIFE_STEP(5),
    .MAX_LEVEL(7), .HITS_PER_LEVEL(2), .MAX_ACTIVE(4)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .hit_pos(hit_pos), .rnd(rnd),
    .map(map_b), .active_cnt(act_b), .level(lvl_b), .hit_pulse(hit_b),
    .miss_pulse(miss_b), .bad_pulse(bad_b), .fsm_state(st_b)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int n);
    while (t < n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got 0x%0h, expected 0x%0h", name, t, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at t=%0d: wait bound expired", name, t);
  endtask

  task automatic whack(input logic [3:0] h);
    hit_pos = h;
    tick();
    hit_pos = NO_HIT;
  endtask

  task automatic restart_a();
    en = 1'b0;
    hit_pos = NO_HIT;
    tick();
    en = 1'b1;
    tick();
    t = 0;
  endtask

  task automatic chk_cleared_a(input string name);
    chk({name, "_map"},   32'(map_a), 32'h0);
    chk({name, "_state"}, 32'(st_a),  32'(IDLE));
    chk({name, "_act"},   32'(act_a), 32'h0);
    chk({name, "_level"}, 32'(lvl_a), 32'h0);
    chk({name, "_pulses"}, {29'd0, hit_a, miss_a, bad_a}, 32'h0);
  endtask

  function automatic logic [3:0] lowest(input logic [8:0] m);
    logic [3:0] r;
    r = NO_HIT;
    for (int i = 8; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  initial begin
    // hit/bad/ignore sequence, applied from t=62 of the second run with
    // moles in holes 3 (expires at edge 71) and 4
    tbl[0] = '{4'd4,  9'h008, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[1] = '{4'd5,  9'h008, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1};
    tbl[2] = '{4'd15, 9'h008, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[3] = '{4'd9,  9'h008, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[4] = '{4'd14, 9'h008, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[5] = '{4'd8,  9'h008, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1};
    tbl[6] = '{4'd15, 9'h008, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[7] = '{4'd15, 9'h008, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
    tbl[8] = '{4'd3,  9'h000, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0};
    tbl[9] = '{4'd15, 9'h000, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0};

    rst = 1'b1; en = 1'b1; en_b = 1'b0; hit_pos = NO_HIT; rnd = 9'h00C;
    tick();
    tick();
    chk_cleared_a("reset");
    chk("reset_map_b", 32'(map_b), 32'h0);

    // Run 1: first spawn, skip at MAX_ACTIVE, expiry
    rst = 1'b0;
    tick();
    t = 0;
    chk("r1_run_entry", 32'(st_a), 32'(RUN));
    goto(20); chk("r1_pick_state", 32'(st_a), 32'(PICK));
    chk("r1_map_before", 32'(map_a), 32'h000);
    goto(21); chk("r1_map_h3", 32'(map_a), 32'h008);
    chk("r1_act1", 32'(act_a), 32'd1);
    goto(41); chk("r1_probe_busy", 32'(st_a), 32'(PICK));
    goto(42); chk("r1_map_h4", 32'(map_a), 32'h018);
    chk("r1_act2", 32'(act_a), 32'd2);
    goto(60); chk("r1_skip_state", 32'(st_a), 32'(RUN));
    chk("r1_skip_map", 32'(map_a), 32'h018);
    goto(70); chk("r1_pre_expire", 32'(map_a), 32'h018);
    chk("r1_no_miss", 32'(miss_a), 32'h0);
    goto(71); chk("r1_expired", 32'(map_a), 32'h010);
    chk("r1_miss", 32'(miss_a), 32'h1);
    goto(72); chk("r1_miss_one_cycle", 32'(miss_a), 32'h0);

    // Run 2: table of whacks, hit beating expiry, level 1 timing
    restart_a();
    goto(62);
    for (int i = 0; i < 10; i++) begin
      whack(tbl[i].hit);
      chk($sformatf("tbl%0d_map", i),   32'(map_a),  32'(tbl[i].map));
      chk($sformatf("tbl%0d_hit", i),   32'(hit_a),  32'(tbl[i].hit_p));
      chk($sformatf("tbl%0d_miss", i),  32'(miss_a), 32'(tbl[i].miss_p));
      chk($sformatf("tbl%0d_bad", i),   32'(bad_a),  32'(tbl[i].bad_p));
      chk($sformatf("tbl%0d_level", i), 32'(lvl_a),  32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_act", i),   32'(act_a),  32'(tbl[i].act));
    end
    goto(77); chk("l1_run", 32'(st_a), 32'(RUN));
    goto(78); chk("l1_pick_at_18", 32'(st_a), 32'(PICK));
    goto(79); chk("l1_map_h3", 32'(map_a), 32'h008);
    goto(95); chk("l1_run2", 32'(st_a), 32'(RUN));
    goto(96); chk("l1_pick2_at_18", 32'(st_a), 32'(PICK));
    goto(98); chk("l1_map_h34", 32'(map_a), 32'h018);
    goto(123); chk("l1_pre_expire", 32'(map_a), 32'h018);
    goto(124); chk("l1_life45", 32'(map_a), 32'h010);
    chk("l1_miss", 32'(miss_a), 32'h1);
    chk("l1_level", 32'(lvl_a), 32'd1);

    // Run 3: 16 hits to saturate the level, then level-7 timing and en drop
    restart_a();
    for (int k = 1; k <= 16; k++) begin
      w = 0;
      while (map_a == 9'h000 && w < 100) begin
        tick();
        w++;
      end
      if (map_a == 9'h000) begin
        timeout($sformatf("sat_wait_mole%0d", k));
      end else begin
        whack(lowest(map_a));
        chk($sformatf("sat_hit%0d", k), 32'(hit_a), 32'h1);
        chk($sformatf("sat_level%0d", k), 32'(lvl_a), (k / 2 > 7) ? 32'd7 : 32'(k / 2));
      end
    end
    w = 0;
    while (!(map_a == 9'h000 && st_a == RUN) && w < 100) begin
      if (map_a != 9'h000) whack(lowest(map_a));
      else tick();
      w++;
    end
    if (!(map_a == 9'h000 && st_a == RUN)) timeout("sat_clear");
    w = 0;
    while (st_a != PICK && w < 40) begin
      tick();
      w++;
    end
    if (st_a != PICK) timeout("sat_wait_pick");
    t = 0;
    goto(1); chk("l7_map_h3", 32'(map_a), 32'h008);
    goto(5); chk("l7_run", 32'(st_a), 32'(RUN));
    goto(6); chk("l7_pick_at_6", 32'(st_a), 32'(PICK));
    goto(8); chk("l7_map_h34", 32'(map_a), 32'h018);
    goto(12); chk("l7_skip", 32'(st_a), 32'(RUN));
    goto(15); chk("l7_pre_expire", 32'(map_a), 32'h018);
    goto(16); chk("l7_life15", 32'(map_a), 32'h010);
    chk("l7_miss", 32'(miss_a), 32'h1);
    goto(18); chk("l7_pick_again", 32'(st_a), 32'(PICK));
    chk("l7_level_sat", 32'(lvl_a), 32'd7);
    en = 1'b0;
    tick();
    chk_cleared_a("en_drop");

    // Run 4 (instance b): probe walks busy holes and wraps 8 -> 0
    en_b = 1'b0;
    tick();
    en_b = 1'b1;
    rnd = 9'h006;
    tick();
    t = 0;
    goto(21); chk("pr_map_h6", 32'(map_b), 32'h040);
    rnd = 9'h007;
    goto(41); chk("pr_map_h67", 32'(map_b), 32'h0C0);
    rnd = 9'h00F;
    goto(60); chk("pr_pick", 32'(st_b), 32'(PICK));
    goto(62); chk("pr_probe3_state", 32'(st_b), 32'(PICK));
    chk("pr_probe3_map", 32'(map_b), 32'h0C0);
    goto(63); chk("pr_map_h8", 32'(map_b), 32'h1C0);
    chk("pr_act3", 32'(act_b), 32'd3);
    goto(83); chk("pr_wrap_pending", 32'(map_b), 32'h1C0);
    goto(84); chk("pr_map_h0", 32'(map_b), 32'h1C1);
    chk("pr_act4", 32'(act_b), 32'd4);
    goto(101); chk("pr_skip_state", 32'(st_b), 32'(RUN));
    chk("pr_skip_map", 32'(map_b), 32'h1C1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
